// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after `start`,
// wrapping around, returned both one-hot and as an index.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = IDX_W'((int'(start) + off) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with an optional per-requester lock that keeps multi-byte messages contiguous.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int START_TO = 16,
  localparam int IDX_W    = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(START_TO + 1)
) (
  input  logic                                  clock,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][UART_BYTE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                    req_last,
  input  logic [NUM_REQ-1:0]                    req_lock,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [UART_BYTE_W-1:0]                tx_data,
  output logic                                  tx_send,
  input  logic                                  tx_busy,
  output logic [IDX_W-1:0]                      grant_id,
  output logic                                  locked,
  output logic                                  tx_timeout
);

  arb_state_t       state;
  logic [CNT_W-1:0] start_cnt;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   search_start;
  logic               accept;

  // While locked only the current owner may compete; the search resumes after the last winner.
  always_comb begin
    owner_mask           = '0;
    owner_mask[grant_id] = 1'b1;
    eligible     = locked ? (req_valid & owner_mask) : req_valid;
    search_start = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
    accept       = rst && (state == IDLE) && !tx_busy && (|eligible);
    req_ready    = accept ? pick_grant : '0;
  end

  rr_picker #(
    .N(NUM_REQ)
  ) u_picker (
    .eligible (eligible),
    .start    (search_start),
    .grant    (pick_grant),
    .grant_idx(pick_idx)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_cnt  <= '0;
      tx_data    <= '0;
      tx_send    <= 1'b0;
      grant_id   <= IDX_W'(NUM_REQ - 1);
      locked     <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      tx_send    <= 1'b0;
      tx_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= req_data[pick_idx];
            grant_id <= pick_idx;
            tx_send  <= 1'b1;
            state    <= ISSUE;
            if (req_last[pick_idx])      locked <= 1'b0;
            else if (req_lock[pick_idx]) locked <= 1'b1;
          end
        end
        ISSUE: begin
          start_cnt <= '0;
          state     <= WAIT_START;
        end
        // Decided one count early so the registered pulse lands START_TO cycles after ISSUE.
        WAIT_START: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (start_cnt == CNT_W'(START_TO - 2)) begin
            tx_timeout <= 1'b1;
            locked     <= 1'b0;
            state      <= IDLE;
          end else begin
            start_cnt <= start_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
